if_fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the RISC-V pipeline. It replaces the fixed PC/mux/IF-ID chain with a decoupled front end:
- a PC generator issues requests to a variable-latency, in-order instruction memory;
- responses are buffered in a fetch queue and handed to decode over a valid/ready handshake;
- EX/MEM branch redirects flush the queue and discard stale in-flight responses.

---
 rtl/if_pkg.sv | 12 +
 rtl/fetch_queue.sv | 54 +++++
 rtl/if_fetch_unit.sv | 122 ++++++++++++
 tb/tb_if_fetch_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// Entry layout in the fetch queue is {pc, instr}, pc in the upper bits.
package if_pkg;
  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [31:0]         instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush (flush beats push), occupancy count and full/empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [W-1:0]               push_dat_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [W-1:0]               head_dat_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == CW'(DEPTH));
  assign count_o    = cnt_q;
  assign head_dat_o = mem_q[rd_q];

  // A pop frees the slot in the same cycle, so push into a full queue is fine then.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_dat_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/if_fetch_unit.sv
// Decoupled fetch stage: PC generator, credit/discard tracking, fetch queue to decode.
// Optional perf counters (perf_fetched, perf_bubbles) built when IF_PERF_CNT_EN is defined.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int              XLEN            = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(RESET_PC_DEF),
  parameter int              QDEPTH          = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_npc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_bubbles
`endif
);
  localparam int CW  = $clog2(MAX_OUTSTANDING+1);
  localparam int QCW = $clog2(QDEPTH+1);

  logic [XLEN-1:0]  pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]    out_q, out_d, disc_q, disc_d;
  logic             run_q;
  logic [QCW-1:0]   q_count;
  logic             q_full, q_empty;
  logic [XLEN+31:0] head;
  logic             req_fire, push, pop;

  // run_q keeps the request port quiet while reset is held and for the first edge after.
  assign imem_req_valid = run_q && !redirect_valid
                       && (32'(out_q) + 32'(q_count) < 32'(QDEPTH))
                       && (32'(out_q) < 32'(MAX_OUTSTANDING));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = imem_rsp_valid && !redirect_valid && (disc_q == '0);
  assign pop            = !q_empty && id_ready;

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_q;
    disc_d   = disc_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[XLEN-1:2], 2'b00};
      rsp_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      out_d    = out_q - CW'(imem_rsp_valid);
      disc_d   = out_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      out_d = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid) begin
        if (disc_q != '0) disc_d = disc_q - CW'(1);
        else              rsp_pc_d = rsp_pc_q + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      disc_q   <= '0;
      run_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
      run_q    <= 1'b1;
    end
  end

  fetch_queue #(.DEPTH(QDEPTH), .W(XLEN+32)) u_queue (
    .clk_i      (clock),
    .rst_ni     (reset),
    .push_i     (push),
    .push_dat_i ({rsp_pc_q, imem_rsp_data}),
    .pop_i      (pop),
    .flush_i    (redirect_valid),
    .head_dat_o (head),
    .count_o    (q_count),
    .full_o     (q_full),
    .empty_o    (q_empty)
  );

  assign id_valid = !q_empty;
  assign id_instr = q_empty ? '0 : head[31:0];
  assign id_pc    = q_empty ? '0 : head[XLEN+31:32];
  assign id_npc   = q_empty ? '0 : head[XLEN+31:32] + XLEN'(4);

  // The credit check should make this unreachable.
  assert property (@(posedge clock) disable iff (!reset) !(push && q_full && !pop));

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetched_q, bubbles_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      if (pop)                 fetched_q <= fetched_q + 32'd1;
      if (id_ready && q_empty) bubbles_q <= bubbles_q + 32'd1;
    end
  end
  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order fixed-latency memory returning addr>>2.
module tb_if_fetch_unit;
  logic        clock, reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc, id_npc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  if_fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_npc         (id_npc)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          cyc, lat, nreq, npops;
  logic [31:0] last_pop_pc;
  int          tests, fails;
  int          pops_before;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: present any due response, log handshakes, return just after the edge.
  task automatic tick();
    pend_t p;
    @(negedge clock);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend[0].addr >> 2;
      void'(pend.pop_front());
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      p.addr = imem_req_addr;
      p.due  = cyc + lat;
      pend.push_back(p);
      nreq++;
    end
    if (id_valid && id_ready) begin
      npops++;
      last_pop_pc = id_pc;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    pend.delete();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    nreq  = 0;
    npops = 0;
  endtask

  task automatic wait_vld(input string tag);
    int n;
    n = 0;
    while (!id_valid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, id_valid}, 32'd1);
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; lat = 1; nreq = 0; npops = 0;
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    id_ready = 1'b0; last_pop_pc = '0;
    #2;
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_npc", id_npc, 32'h0);

    // 1: L=1 stream, first instruction three cycles after release, then gap-free
    do_reset();
    lat = 1; id_ready = 1'b1;
    tick();
    chk("t1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t1_req_addr", imem_req_addr, 32'h0);
    tick();
    tick();
    chk("t1_first_valid", {31'd0, id_valid}, 32'd1);
    chk("t1_first_pc", id_pc, 32'h0);
    chk("t1_first_instr", id_instr, 32'h0);
    chk("t1_first_npc", id_npc, 32'h4);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("t1_stream_valid", {31'd0, id_valid}, 32'd1);
      chk("t1_stream_pc", id_pc, 32'(i * 4));
      chk("t1_stream_instr", id_instr, 32'(i));
    end

    // 2: decode stalled, queue credit caps issue at QDEPTH
    do_reset();
    lat = 1; id_ready = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("t2_nreq", 32'(nreq), 32'd4);
    chk("t2_req_valid_low", {31'd0, imem_req_valid}, 32'd0);
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_valid", {31'd0, id_valid}, 32'd1);
      chk("t2_drain_pc", id_pc, 32'(i * 4));
      tick();
    end
    wait_vld("t2_refill_wait");
    chk("t2_refill_pc", id_pc, 32'h10);

    // 3: L=3, redirect with two requests in flight
    do_reset();
    lat = 3; id_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("t3_max_outstanding", {31'd0, imem_req_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    chk("t3_redirect_addr", imem_req_addr, 32'h100);
    wait_vld("t3_wait");
    chk("t3_pc", id_pc, 32'h100);
    chk("t3_instr", id_instr, 32'h40);
    chk("t3_npc", id_npc, 32'h104);

    // 4: redirect coincident with response and decode pop
    do_reset();
    lat = 1; id_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t4_pre_pc", id_pc, 32'h8);
    pops_before = npops;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("t4_pop_count", 32'(npops), 32'(pops_before + 1));
    chk("t4_pop_pc", last_pop_pc, 32'h8);
    chk("t4_flushed", {31'd0, id_valid}, 32'd0);
    chk("t4_new_addr", imem_req_addr, 32'h200);
    wait_vld("t4_wait");
    chk("t4_new_pc", id_pc, 32'h200);

    // 5: memory not ready, address held
    do_reset();
    lat = 1; id_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_addr", imem_req_addr, 32'h0);
      chk("t5_hold_valid", {31'd0, imem_req_valid}, 32'd1);
      tick();
    end
    chk("t5_no_req", 32'(nreq), 32'd0);
    chk("t5_no_id", {31'd0, id_valid}, 32'd0);
    imem_req_ready = 1'b1;
    wait_vld("t5_wait");
    chk("t5_pc", id_pc, 32'h0);

    // 6: asynchronous reset mid-stream
    do_reset();
    lat = 3; id_ready = 1'b1;
    wait_vld("t6_pre_wait");
    tick();
    reset = 1'b0;
    #1;
    chk("t6_async_valid", {31'd0, id_valid}, 32'd0);
    chk("t6_async_req", {31'd0, imem_req_valid}, 32'd0);
    chk("t6_async_pc", id_pc, 32'h0);
    pend.delete();
    imem_rsp_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    wait_vld("t6_post_wait");
    chk("t6_post_pc", id_pc, 32'h0);
    chk("t6_post_instr", id_instr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
